// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus instruction fetch stage.
// Issues word addresses to a 1-cycle synchronous instruction memory,
// buffers responses with their PCs in a small FIFO and hands them
// downstream over valid/ready. Jump/branch redirects flush wrong-path work.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   imem_req/addr       read request and word address (addr == fetch_pc)
//   imem_rdata          read data, one cycle after an accepted request
//   jump_en/target      absolute redirect (wins over branch)
//   branch_en/base/off  taken branch, target = base + sext(offset)
//   out_valid/ready     downstream handshake on the FIFO head
//   out_instr/out_pc    head entry, last shown value while empty
//   redirect_count      saturating count of redirect cycles
module pc_fetch_unit #(
   parameter int              INSTR_W  = 72,
   parameter int              PC_W     = 32,
   parameter int              OFF_W    = 16,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               jump_en,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               branch_en,
   input  logic [PC_W-1:0]    branch_base,
   input  logic [OFF_W-1:0]   branch_offset,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   redirect_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]    fetch_pc;
   logic [PC_W-1:0]    req_pc;
   logic               inflight;

   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic [PC_W-1:0]    fifo_pc    [DEPTH];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;
   logic [CW-1:0]      count;

   logic [INSTR_W-1:0] hold_instr;
   logic [PC_W-1:0]    hold_pc;

   logic               redirect;
   logic [PC_W-1:0]    off_ext;
   logic [PC_W-1:0]    target_pc;
   logic               pop;
   logic               push;
   logic [CW:0]        occ_after;

   assign redirect = jump_en | branch_en;

   // size cast of a signed operand sign-extends the offset
   assign off_ext = PC_W'($signed(branch_offset));

   always_comb begin
      target_pc = branch_base + off_ext;
      unique case (1'b1)
         jump_en: target_pc = jump_target;
         default: target_pc = branch_base + off_ext;
      endcase
   end

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;

   // a response due this cycle is dropped when the redirect lands
   assign push = inflight & ~redirect;

   // room left once this cycle's pop and pending response settle
   assign occ_after = {1'b0, count}
                    + (CW+1)'(inflight)
                    - (CW+1)'(pop);

   assign imem_req  = rst & ~redirect
                    & (occ_after < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc;

   // while empty the outputs keep whatever was shown last
   assign out_instr = out_valid ? fifo_instr[rd_ptr] : hold_instr;
   assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : hold_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         inflight <= 1'b0;
      end else if (redirect) begin
         fetch_pc <= target_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= req_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_instr <= '0;
         hold_pc    <= '0;
      end else if (out_valid) begin
         hold_instr <= fifo_instr[rd_ptr];
         hold_pc    <= fifo_pc[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redirect_count <= '0;
      end else if (redirect && (redirect_count != '1)) begin
         redirect_count <= redirect_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus random check of pc_fetch_unit
// against a queue-based reference model.
module tb_pc_fetch_unit;

   localparam int IW = 72;
   localparam int PW = 8;
   localparam int OW = 6;
   localparam int D  = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata = '0;
   logic          jump_en = 1'b0;
   logic [PW-1:0] jump_target = '0;
   logic          branch_en = 1'b0;
   logic [PW-1:0] branch_base = '0;
   logic [OW-1:0] branch_offset = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [IW-1:0] out_instr;
   logic [PW-1:0] out_pc;
   logic [CW-1:0] redirect_count;

   int total = 0;
   int bad   = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .INSTR_W (IW),
      .PC_W    (PW),
      .OFF_W   (OW),
      .DEPTH   (D),
      .RESET_PC(8'h00),
      .CNT_W   (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .branch_en     (branch_en),
      .branch_base   (branch_base),
      .branch_offset (branch_offset),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .redirect_count(redirect_count)
   );

   function automatic logic [IW-1:0] instr_of(logic [PW-1:0] a);
      return {24'hC0FFEE, a ^ 8'h5A, 40'(a) + 40'h100};
   endfunction

   // memory: data for the requested word one cycle later, junk otherwise
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= instr_of(imem_addr);
      else          imem_rdata <= IW'({$urandom(), $urandom(), $urandom()});
   end

   // reference model
   typedef struct {
      logic [PW-1:0] pc;
      logic [IW-1:0] ins;
   } ent_t;

   ent_t          q[$];
   bit            m_inf = 1'b0;
   logic [PW-1:0] m_inf_pc = '0;
   logic [PW-1:0] m_fpc = '0;
   logic [PW-1:0] m_last_pc = '0;
   logic [IW-1:0] m_last_ins = '0;
   int            m_cnt = 0;

   function automatic bit m_pop();
      return (q.size() > 0) && out_ready;
   endfunction

   function automatic bit m_req();
      if (!rst || jump_en || branch_en) return 1'b0;
      return (q.size() + int'(m_inf) - int'(m_pop())) < D;
   endfunction

   function automatic logic [PW-1:0] m_target();
      int t;
      if (jump_en) return jump_target;
      t = int'(branch_base) + int'($signed(branch_offset));
      return PW'(((t % 256) + 256) % 256);
   endfunction

   always @(posedge clk or negedge rst) begin : mdl
      bit            p;
      bit            r;
      logic [PW-1:0] t;
      if (!rst) begin
         q.delete();
         m_inf      = 1'b0;
         m_fpc      = '0;
         m_last_pc  = '0;
         m_last_ins = '0;
         m_cnt      = 0;
      end else begin
         p = m_pop();
         r = m_req();
         t = m_target();
         if (q.size() > 0) begin
            m_last_pc  = q[0].pc;
            m_last_ins = q[0].ins;
         end
         if (p) void'(q.pop_front());
         if (jump_en || branch_en) begin
            q.delete();
            m_inf = 1'b0;
            m_fpc = t;
            if (m_cnt < 15) m_cnt++;
         end else begin
            if (m_inf) q.push_back('{m_inf_pc, instr_of(m_inf_pc)});
            m_inf    = r;
            m_inf_pc = m_fpc;
            if (r) m_fpc = m_fpc + 8'd1;
         end
      end
   end

   task automatic chk(string nm, logic [IW-1:0] got, logic [IW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   task automatic chkb(string nm, logic got, logic exp);
      chk(nm, IW'(got), IW'(exp));
   endtask

   task automatic chkp(string nm, logic [PW-1:0] got, logic [PW-1:0] exp);
      chk(nm, IW'(got), IW'(exp));
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         chkb("cyc_req", imem_req, m_req());
         chkp("cyc_addr", imem_addr, m_fpc);
         chkb("cyc_valid", out_valid, q.size() > 0);
         chkp("cyc_pc", out_pc,
              (q.size() > 0) ? q[0].pc : m_last_pc);
         chk("cyc_instr", out_instr,
             (q.size() > 0) ? q[0].ins : m_last_ins);
         chk("cyc_rcnt", IW'(redirect_count), IW'(m_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   logic [IW-1:0] tmp;
   int            r;

   initial begin
      repeat (3) @(posedge clk);
      cmp_on = 1'b1;
      #1;

      // streaming from reset
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      chkb("t1_c0_req", imem_req, 1'b1);
      chkp("t1_c0_addr", imem_addr, 8'h00);
      chkb("t1_c0_valid", out_valid, 1'b0);
      step();
      #1;
      chkp("t1_c1_addr", imem_addr, 8'h01);
      step();
      #1;
      tmp = out_instr;
      chkb("t1_c2_valid", out_valid, 1'b1);
      chkp("t1_c2_pc", out_pc, 8'h00);
      chk("t1_c2_lo", IW'(tmp[15:0]), IW'(16'h0100));
      step();
      #1;
      chkp("t1_c3_pc", out_pc, 8'h01);
      step();
      #1;
      chkp("t1_c4_pc", out_pc, 8'h02);
      step();
      #1;
      chkb("t1_c5_valid", out_valid, 1'b1);
      chkp("t1_c5_pc", out_pc, 8'h03);

      // backpressure
      out_ready = 1'b0;
      restart();
      step();
      step();
      #1;
      chkb("t2_c2_valid", out_valid, 1'b1);
      chkb("t2_c2_req", imem_req, 1'b0);
      step();
      #1;
      chkb("t2_c3_req", imem_req, 1'b0);
      chkp("t2_c3_pc", out_pc, 8'h00);
      step();
      #1;
      out_ready = 1'b1;
      #1;
      chkb("t2_c4_req", imem_req, 1'b1);
      chkp("t2_c4_addr", imem_addr, 8'h02);
      step();
      #1;
      chkp("t2_c5_pc", out_pc, 8'h01);
      step();
      #1;
      chkp("t2_c6_pc", out_pc, 8'h02);

      // branch while streaming
      restart();
      repeat (18) step();
      branch_en = 1'b1;
      branch_base = 8'h10;
      branch_offset = 6'h3C;
      #1;
      chkb("t3_redir_req", imem_req, 1'b0);
      chkp("t3_redir_pc", out_pc, 8'h10);
      step();
      branch_en = 1'b0;
      #1;
      chkb("t3_req", imem_req, 1'b1);
      chkp("t3_addr", imem_addr, 8'h0C);
      chk("t3_rcnt", IW'(redirect_count), IW'(4'd1));
      chkb("t3_flushed", out_valid, 1'b0);
      step();
      #1;
      chkb("t3_gap", out_valid, 1'b0);
      step();
      #1;
      chkb("t3_valid", out_valid, 1'b1);
      chkp("t3_first_pc", out_pc, 8'h0C);

      // jump beats branch
      jump_en = 1'b1;
      jump_target = 8'h40;
      branch_en = 1'b1;
      branch_base = 8'h10;
      branch_offset = 6'h08;
      step();
      jump_en = 1'b0;
      branch_en = 1'b0;
      #1;
      chkp("t4_addr", imem_addr, 8'h40);

      // wrap around the top of the PC space
      jump_en = 1'b1;
      jump_target = 8'hFE;
      step();
      jump_en = 1'b0;
      #1;
      chkp("t5_addr", imem_addr, 8'hFE);
      step();
      step();
      #1;
      chkp("t5_pc0", out_pc, 8'hFE);
      step();
      #1;
      chkp("t5_pc1", out_pc, 8'hFF);
      step();
      #1;
      chkp("t5_pc2", out_pc, 8'h00);
      step();
      #1;
      chkp("t5_pc3", out_pc, 8'h01);
      branch_en = 1'b1;
      branch_base = 8'h02;
      branch_offset = 6'h3D;
      step();
      branch_en = 1'b0;
      #1;
      chkp("t5_br_addr", imem_addr, 8'hFF);
      chk("t5_rcnt", IW'(redirect_count), IW'(4'd4));

      // async reset with the FIFO full
      out_ready = 1'b0;
      repeat (4) step();
      #1;
      chkb("t6_full_valid", out_valid, 1'b1);
      chkb("t6_full_req", imem_req, 1'b0);
      rst = 1'b0;
      #1;
      chkb("t6_rst_valid", out_valid, 1'b0);
      chkp("t6_rst_pc", out_pc, 8'h00);
      chk("t6_rst_instr", out_instr, '0);
      chkb("t6_rst_req", imem_req, 1'b0);
      chkp("t6_rst_addr", imem_addr, 8'h00);
      chk("t6_rst_rcnt", IW'(redirect_count), '0);
      step();
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      chkp("t6_c0_addr", imem_addr, 8'h00);
      step();
      step();
      #1;
      chkb("t6_c2_valid", out_valid, 1'b1);
      chkp("t6_c2_pc", out_pc, 8'h00);
      chk("t6_c2_instr", out_instr, instr_of(8'h00));

      // back-to-back jumps and counter saturation
      for (int i = 0; i < 20; i++) begin
         jump_en = 1'b1;
         jump_target = 8'h80 + PW'(i);
         step();
      end
      jump_en = 1'b0;
      #1;
      chkp("t7_addr", imem_addr, 8'h93);
      chk("t7_rcnt", IW'(redirect_count), IW'(4'hF));

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         step();
         out_ready = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 99));
         jump_en = (r < 3);
         branch_en = (r >= 2) && (r < 7);
         jump_target = PW'($urandom());
         branch_base = PW'($urandom());
         branch_offset = OW'($urandom());
         if (i == 2000) rst = 1'b0;
         if (i == 2003) rst = 1'b1;
      end
      jump_en = 1'b0;
      branch_en = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter and instruction-fetch stage for the processor family; supersedes the fixed-width PC plus fetch pair.
- Issues word addresses to a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents them downstream over a valid/ready handshake; jump/branch redirects flush wrong-path work.

Parameters:
INSTR_W, 72, instruction width in bits
PC_W, 32, program counter width (word address)
OFF_W, 16, signed branch offset width (OFF_W <= PC_W)
DEPTH, 2, fetch FIFO entries (power of two, >= 2)
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, redirect counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  instruction memory read request
imem_addr  out  PC_W  read address, valid when imem_req=1
imem_rdata  in  INSTR_W  read data, valid the cycle after an accepted request
jump_en  in  1  absolute redirect request
jump_target  in  PC_W  absolute jump address
branch_en  in  1  taken-branch redirect request
branch_base  in  PC_W  PC of the branch instruction
branch_offset  in  OFF_W  signed word offset
out_valid  out  1  fetched instruction available
out_ready  in  1  consumer accepts head entry
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  PC of head instruction
redirect_count  out  CNT_W  saturating count of redirects taken

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, FIFO empty, no in-flight request, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, redirect_count=0.
- Reset mid-operation discards the FIFO and any in-flight response immediately. The response arriving after rst deasserts is ignored.
- imem_addr always equals fetch_pc.
- Issue rule: imem_req=1 when (occupancy + inflight − pop) < DEPTH and no redirect this cycle.
  - pop = out_valid & out_ready.
  - inflight = 1 if a request was issued last cycle and not squashed.
  - When imem_req=1, fetch_pc increments by 1 modulo 2^PC_W. 2^PC_W−1 wraps to 0.
- Response: the cycle after a request, imem_rdata and the registered request PC are written to the FIFO tail at that clock edge, unless squashed.
- Latency: request in cycle N → out_valid=1 in cycle N+2 if the FIFO was empty.
- Throughput: with out_ready held at 1 there is one instruction per cycle sustained, with no bubbles.
- Output: out_valid = FIFO non-empty. out_instr/out_pc are driven from the head entry and hold stable while out_valid=1 and out_ready=0.
  - When out_valid=0, out_instr/out_pc keep their last value (0 after reset).
- Simultaneous push and pop on a full FIFO is legal and keeps occupancy unchanged.
- Redirect (jump_en | branch_en sampled at clock edge):
  - jump_en has priority over branch_en when both are asserted.
  - Branch target = branch_base + sign-extended branch_offset, modulo 2^PC_W (wraps both directions).
  - In the redirect cycle imem_req=0. At the edge: fetch_pc←target, FIFO cleared, in-flight response squashed.
  - A pop handshake completing in the redirect cycle counts as consumed. All remaining entries are discarded.
  - Next cycle: imem_req=1, imem_addr=target. First target instruction reaches out_valid two cycles later.
  - Back-to-back redirects: each one restarts from its own target. The last one wins.
- redirect_count increments by 1 per redirect cycle and saturates at 2^CNT_W−1.
- No state machine beyond FIFO pointers and occupancy, the inflight flag, and fetch_pc. The idle/streaming/redirect behaviour is fully defined by the rules above.

Test Plan:
- Reset release, out_ready=1, imem returns mem[a]=a+0x100: cycle 0 req addr 0; cycle 2 out_valid=1, out_pc=0, out_instr=0x100; then out_pc = 1, 2, 3 on consecutive cycles with no gaps.
- Backpressure: out_ready=0 from cycle 2 → FIFO fills to 2 entries (PCs 0, 1), imem_req drops to 0, and out_pc stays 0. Raising out_ready → PCs 1, 2 appear with no loss or duplication.
- Branch: branch_en with base=0x10, offset=−4 while streaming → next request addr 0x0C; stale PCs 0x11–0x12 never appear; first out_pc=0x0C two cycles after the request; redirect_count=1.
- Jump and branch in the same cycle: jump_target=0x40, base=0x10, offset=+8 → fetch resumes at 0x40, not 0x18.
- Wrap: PC_W=8, start streaming at 0xFE → out_pc sequence 0xFE, 0xFF, 0x00, 0x01. Branch base=0x02, offset=−3 → target 0xFF.
- Async reset asserted mid-stream with FIFO full → outputs return to reset values without a clock edge. After release, the first out_pc=RESET_PC and no pre-reset instruction is emitted.
